fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx_pkg.sv | 26 ++
 rtl/fifo_uart_tx_baud.sv | 40 ++++
 rtl/fifo_uart_tx.sv | 137 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx_pkg
// Purpose  : Shared UART definitions: serial FSM state encoding and the
//            clocks-per-bit derivation. Intended for both the TX and the
//            future RX block so the two sides always agree on the encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fifo_uart_tx_pkg;

    // Serial line frame phases; encoding is fixed so RX can share it.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Clocks per serial bit (integer division, remainder discarded).
    function automatic int calc_baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_uart_tx_baud.sv
`default_nettype none
// ============================================================================
// Module   : baud_tick_gen
// Purpose  : Free-running bit-period counter. Emits a one-cycle tick on the
//            last clock of every DIV-clock bit period. A synchronous clear
//            restarts the period so the next tick is a full DIV clocks away.
// Ports    : clk   - system clock (rising edge)
//            rst   - synchronous active-low reset
//            clear - synchronous counter restart
//            tick  - high on the final clock of each bit period
// Revision : 1.0 - initial release
// ============================================================================
module baud_tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int                 c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Purpose  : UART transmitter fed from a first-word-fall-through FIFO. Pops
//            one word when idle, then sends start bit, BIT_WIDTH data bits
//            LSB first and one stop bit, each BAUD_DIV clocks long.
// Ports    : clk      - system clock (rising edge)
//            rst      - synchronous active-low reset
//            empty    - upstream FIFO has no data
//            pop_data - FIFO head word, valid while empty=0
//            pop      - one-cycle consume strobe to the FIFO
//            tx       - registered serial output, idle high
//            tx_busy  - frame in progress
//            tx_done  - one-cycle pulse on the last stop-bit clock
// Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 empty,
    input  logic [BIT_WIDTH-1:0] pop_data,
    output logic                 pop,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int                     c_baud_div  = calc_baud_div(CLK_FREQ, BAUD);
    localparam int                     c_bit_cnt_w = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;
    localparam logic [c_bit_cnt_w-1:0] c_last_bit  = c_bit_cnt_w'(BIT_WIDTH - 1);

    uart_state_e            r_state;
    uart_state_e            w_state_next;
    logic [BIT_WIDTH-1:0]   r_shift;
    logic [BIT_WIDTH-1:0]   w_shift_next;
    logic [c_bit_cnt_w-1:0] r_bit_cnt;
    logic [c_bit_cnt_w-1:0] w_bit_cnt_next;
    logic                   r_tx;
    logic                   w_tx_next;
    logic                   w_tick;
    logic                   w_clear;
    logic                   w_pop;
    logic                   w_done;

    // Holding the counter clear throughout IDLE guarantees the start bit
    // begins a fresh, full-length bit period.
    assign w_clear = (r_state == IDLE);

    baud_tick_gen #(
        .DIV (c_baud_div)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .tick  (w_tick)
    );

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_pop          = 1'b0;
        w_done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (!empty) begin
                    w_pop          = 1'b1;
                    w_shift_next   = pop_data;
                    w_bit_cnt_next = '0;
                    w_state_next   = START;
                end
            end
            START: begin
                if (w_tick) begin
                    w_bit_cnt_next = '0;
                    w_state_next   = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_cnt == c_last_bit) begin
                        w_state_next = STOP;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Line level is derived from the state being entered so the registered
    // tx lines up exactly with the state it belongs to.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_tx      <= w_tx_next;
        end
    end

    // Gating with rst keeps the FIFO untouched while reset is held.
    assign pop     = w_pop & rst;
    assign tx      = r_tx;
    assign tx_busy = (r_state != IDLE);
    assign tx_done = w_done;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_uart_tx
// Purpose  : Self-checking bench for fifo_uart_tx. The bench owns a queue
//            acting as the upstream FIFO and predicts the serial waveform
//            from the frame layout (age of the frame in clocks).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int CLK_FREQ = 100;
    localparam int BAUD     = 10;
    localparam int BW       = 8;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int FRAME    = (BW + 2) * DIV;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          empty = 1'b1;
    logic [BW-1:0] pop_data = '0;
    logic          pop;
    logic          tx;
    logic          tx_busy;
    logic          tx_done;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .BIT_WIDTH (BW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .empty    (empty),
        .pop_data (pop_data),
        .pop      (pop),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    int            vectors     = 0;
    int            miscompares = 0;
    logic [BW-1:0] fifo_q[$];
    logic [BW-1:0] sent_q[$];
    logic [BW-1:0] rx_q[$];
    int            pop_cycles[$];
    int            age       = 0;    // clocks since the pop; 0 = idle
    logic [BW-1:0] cur_word  = '0;
    logic [BW-1:0] rx_byte   = '0;
    bit            noise     = 1'b0;
    int            cycle     = 0;
    int            done_cnt  = 0;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @cycle %0d: observed %b expected %b", tag, cycle, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive FIFO, check outputs mid-cycle, then advance the model.
    task automatic step();
        logic exp_tx, exp_busy, exp_done, exp_pop;
        if (noise && age > 0) begin
            empty    = 1'($urandom_range(0, 1));
            pop_data = BW'($urandom);
        end else begin
            empty    = (fifo_q.size() == 0);
            pop_data = empty ? BW'($urandom) : fifo_q[0];
        end
        @(negedge clk);
        if (age == 0) begin
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_pop  = rst && !empty;
        end else begin
            exp_busy = 1'b1;
            exp_done = (age == FRAME);
            exp_pop  = 1'b0;
            if (age <= DIV)                exp_tx = 1'b0;
            else if (age <= (BW + 1) * DIV) exp_tx = cur_word[(age - DIV - 1) / DIV];
            else                           exp_tx = 1'b1;
        end
        chk_bit("pop", pop, exp_pop);
        chk_bit("tx", tx, exp_tx);
        chk_bit("tx_busy", tx_busy, exp_busy);
        chk_bit("tx_done", tx_done, exp_done);
        if (pop === 1'b1) pop_cycles.push_back(cycle);
        if (tx_done === 1'b1) done_cnt++;
        // Independent line decode: sample mid-bit of each data bit.
        if (age > DIV && age <= (BW + 1) * DIV && ((age - DIV - 1) % DIV) == DIV / 2)
            rx_byte[(age - DIV - 1) / DIV] = tx;
        if (age == (BW + 1) * DIV + DIV / 2 && tx === 1'b1)
            rx_q.push_back(rx_byte);
        @(posedge clk);
        cycle++;
        if (!rst) begin
            if (age > 0) void'(sent_q.pop_back());
            age = 0;
        end else if (age == 0) begin
            if (exp_pop) begin
                age      = 1;
                cur_word = pop_data;
                void'(fifo_q.pop_front());
                sent_q.push_back(pop_data);
            end
        end else begin
            age = (age == FRAME) ? 0 : age + 1;
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int pops_before;
        int dones_before;
        int guard;

        // Reset: first edge establishes the state, then check held reset.
        rst = 1'b0;
        @(posedge clk);
        #1;
        run(3);

        // Single frame 8'hA5.
        rst = 1'b1;
        fifo_q.push_back(8'hA5);
        pops_before  = pop_cycles.size();
        dones_before = done_cnt;
        run(FRAME + 20);
        chk_int("single_pops", pop_cycles.size() - pops_before, 1);
        chk_int("single_done", done_cnt - dones_before, 1);

        // Back-to-back frames 01, FF.
        fifo_q.push_back(8'h01);
        fifo_q.push_back(8'hFF);
        pops_before  = pop_cycles.size();
        dones_before = done_cnt;
        run(2 * FRAME + 20);
        chk_int("b2b_pops", pop_cycles.size() - pops_before, 2);
        chk_int("b2b_done", done_cnt - dones_before, 2);
        if (pop_cycles.size() - pops_before == 2)
            chk_int("b2b_spacing", pop_cycles[pops_before + 1] - pop_cycles[pops_before], FRAME + 1);

        // Empty FIFO for 500 clocks.
        pops_before = pop_cycles.size();
        run(500);
        chk_int("empty_pops", pop_cycles.size() - pops_before, 0);

        // Reset at clock 45 of an 8'h3C frame, word re-queued for retry.
        fifo_q.push_back(8'h3C);
        guard = 0;
        step();
        while (age != 45 && guard < 200) begin
            step();
            guard++;
        end
        chk_int("reset_reach45", age, 45);
        fifo_q.push_back(8'h3C);
        rst = 1'b0;
        run(3);
        rst = 1'b1;
        pops_before = pop_cycles.size();
        run(FRAME + 10);
        chk_int("reset_restart_pops", pop_cycles.size() - pops_before, 1);

        // Mid-frame changes on empty/pop_data must not disturb the frame.
        fifo_q.push_back(BW'($urandom));
        noise       = 1'b1;
        pops_before = pop_cycles.size();
        run(FRAME + 5);
        noise = 1'b0;
        chk_int("noise_pops", pop_cycles.size() - pops_before, 1);

        // Randomized words back to back.
        for (int i = 0; i < 6; i++) fifo_q.push_back(BW'($urandom));
        guard = 0;
        while ((fifo_q.size() != 0 || age != 0) && guard < 10 * (FRAME + 1)) begin
            step();
            guard++;
        end
        run(5);
        chk_int("random_drain", fifo_q.size(), 0);

        // Decoded line content vs words popped.
        chk_int("frames_decoded", rx_q.size(), sent_q.size());
        for (int i = 0; i < sent_q.size() && i < rx_q.size(); i++)
            chk_int("decode_word", int'(rx_q[i]), int'(sent_q[i]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
